// File: rtl/branch_result_sender_if.sv
// branch_result_sender_if: resolved-branch input lanes, predictor-update output lanes and squash handshake
interface branch_result_sender_if #(
  parameter int ISSUE_WIDTH = 2,
  parameter int HIST_BITS = 10,
  parameter int CNT_BITS = 2
);
  logic [ISSUE_WIDTH-1:0] exValid, exIsCondBr, exPredTaken, exExecTaken, exTargetMatch;
  logic [ISSUE_WIDTH-1:0][HIST_BITS-1:0] exHistory, brHistory;
  logic [ISSUE_WIDTH-1:0][CNT_BITS-1:0] exPrevCnt, brPrevCnt;
  logic exReady, outReady, squashDone, inSquash;
  logic [ISSUE_WIDTH-1:0] brValid, brMispred, brExecTaken, brIsCondBr;
  logic [15:0] mispredCount;
  modport master (
    output exValid, exIsCondBr, exPredTaken, exExecTaken, exTargetMatch, exHistory, exPrevCnt,
    output outReady, squashDone,
    input exReady, brValid, brMispred, brExecTaken, brIsCondBr, brHistory, brPrevCnt,
    input inSquash, mispredCount
  );
  modport slave (
    input exValid, exIsCondBr, exPredTaken, exExecTaken, exTargetMatch, exHistory, exPrevCnt,
    input outReady, squashDone,
    output exReady, brValid, brMispred, brExecTaken, brIsCondBr, brHistory, brPrevCnt,
    output inSquash, mispredCount
  );
endinterface

// File: rtl/branch_result_sender.sv
// branch_result_sender: queues resolved branches for predictor update, dropping wrong-path results after a mispredict
module branch_result_sender #(
  parameter int ISSUE_WIDTH = 2,
  parameter int HIST_BITS = 10,
  parameter int CNT_BITS = 2,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  branch_result_sender_if.slave io
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(ISSUE_WIDTH + 1);
  typedef struct packed {
    logic mispred;
    logic execTaken;
    logic isCondBr;
    logic [HIST_BITS-1:0] history;
    logic [CNT_BITS-1:0] prevCnt;
  } entry_t;
  typedef enum logic {RUN, SQUASH} state_t;
  state_t state, stateNext;
  entry_t mem [DEPTH];
  entry_t rd [ISSUE_WIDTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [15:0] mispredCnt;
  logic [ISSUE_WIDTH-1:0] laneMispred, accept, live;
  logic [ISSUE_WIDTH-1:0][PW-1:0] slot;
  logic [LW-1:0] pushCnt, popCnt;
  logic ready, blocked, mispredEnq;
  // lane classification, in-order acceptance with cut-off after the oldest mispredict, and pop sizing
  always_comb begin
    ready = (CW'(DEPTH) - count) >= CW'(ISSUE_WIDTH);
    laneMispred = '0;
    accept = '0;
    slot = '0;
    pushCnt = '0;
    blocked = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      laneMispred[i] = io.exIsCondBr[i] ? (io.exPredTaken[i] != io.exExecTaken[i]) || (io.exExecTaken[i] && !io.exTargetMatch[i]) : !io.exTargetMatch[i];
      accept[i] = rst && io.exValid[i] && ready && state == RUN && !blocked;
      slot[i] = tail + PW'(pushCnt);
      pushCnt = pushCnt + LW'(accept[i]);
      blocked = blocked || (io.exValid[i] && laneMispred[i]);
    end
    mispredEnq = |(accept & laneMispred);
    popCnt = io.outReady ? (count < CW'(ISSUE_WIDTH) ? LW'(count) : LW'(ISSUE_WIDTH)) : '0;
  end
  // next state: a queued mispredict opens the squash window, squashDone closes it
  always_comb begin
    stateNext = state == RUN ? (mispredEnq ? SQUASH : RUN) : (io.squashDone ? RUN : SQUASH);
  end
  // state register, pointers, occupancy and saturating mispredict counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      head <= '0;
      tail <= '0;
      count <= '0;
      mispredCnt <= '0;
    end else begin
      state <= stateNext;
      head <= head + PW'(popCnt);
      tail <= tail + PW'(pushCnt);
      count <= count + CW'(pushCnt) - CW'(popCnt);
      if (mispredEnq && mispredCnt != 16'hFFFF) mispredCnt <= mispredCnt + 16'd1;
    end
  end
  // result storage; accepted lanes land in consecutive slots from tail
  always_ff @(posedge clk) begin
    for (int i = 0; i < ISSUE_WIDTH; i++)
      if (accept[i]) mem[slot[i]] <= '{mispred: laneMispred[i], execTaken: io.exExecTaken[i], isCondBr: io.exIsCondBr[i], history: io.exHistory[i], prevCnt: io.exPrevCnt[i]};
  end
  // present the oldest entries from head; empty lanes and reset force everything to zero
  always_comb begin
    io.exReady = ready || !rst;
    io.inSquash = rst && state == SQUASH;
    io.mispredCount = mispredCnt;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      rd[i] = mem[head + PW'(i)];
      live[i] = rst && CW'(i) < count;
      io.brValid[i] = live[i];
      io.brMispred[i] = live[i] && rd[i].mispred;
      io.brExecTaken[i] = live[i] && rd[i].execTaken;
      io.brIsCondBr[i] = live[i] && rd[i].isCondBr;
      io.brHistory[i] = live[i] ? rd[i].history : '0;
      io.brPrevCnt[i] = live[i] ? rd[i].prevCnt : '0;
    end
  end
endmodule

// File: tb/tb_branch_result_sender.sv
// tb_branch_result_sender: directed scenarios plus randomized traffic checked against a queue-based model
module tb_branch_result_sender;
  localparam int IW = 2;
  localparam int HB = 10;
  localparam int CB = 2;
  localparam int D = 8;
  typedef struct {
    logic m, t, c;
    logic [HB-1:0] h;
    logic [CB-1:0] p;
  } ent_t;
  logic clk = 0;
  logic rst;
  int errors = 0;
  int checks = 0;
  bit chkEn = 0;
  ent_t q[$];
  bit sq = 0;
  int mc = 0;
  branch_result_sender_if #(.ISSUE_WIDTH(IW), .HIST_BITS(HB), .CNT_BITS(CB)) bif ();
  branch_result_sender #(.ISSUE_WIDTH(IW), .HIST_BITS(HB), .CNT_BITS(CB), .DEPTH(D)) dut (.clk(clk), .rst(rst), .io(bif));
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isMis(input bit c, input bit p, input bit e, input bit m);
    if (!c) return !m;
    if (p != e) return 1;
    return e && !m;
  endfunction

  // reference: queue of pending results, squash flag and mispredict tally
  always @(posedge clk) begin
    int n;
    ent_t x;
    if (!rst) begin
      q.delete();
      sq = 0;
      mc = 0;
    end else begin
      n = q.size();
      if (bif.outReady) repeat ((n < IW) ? n : IW) void'(q.pop_front());
      if (sq) begin
        if (bif.squashDone) sq = 0;
      end else if (D - n >= IW) begin
        for (int i = 0; i < IW; i++) begin
          if (bif.exValid[i]) begin
            x.m = isMis(bif.exIsCondBr[i], bif.exPredTaken[i], bif.exExecTaken[i], bif.exTargetMatch[i]);
            x.t = bif.exExecTaken[i];
            x.c = bif.exIsCondBr[i];
            x.h = bif.exHistory[i];
            x.p = bif.exPrevCnt[i];
            q.push_back(x);
            if (x.m) begin
              sq = 1;
              if (mc < 65535) mc++;
              break;
            end
          end
        end
      end
    end
  end

  // every-cycle comparison of all outputs against the reference
  always @(negedge clk) begin
    int n;
    ent_t x;
    bit v;
    if (chkEn) begin
      n = q.size();
      cmp("exReady", 64'(bif.exReady), 64'(!rst || (D - n) >= IW));
      cmp("inSquash", 64'(bif.inSquash), 64'(rst && sq));
      cmp("mispredCount", 64'(bif.mispredCount), 64'(mc));
      for (int i = 0; i < IW; i++) begin
        v = rst && i < n;
        x = v ? q[i] : '{m: 0, t: 0, c: 0, h: '0, p: '0};
        cmp($sformatf("lane%0d", i),
            64'({bif.brValid[i], bif.brMispred[i], bif.brExecTaken[i], bif.brIsCondBr[i], bif.brHistory[i], bif.brPrevCnt[i]}),
            64'({v, x.m, x.t, x.c, x.h, x.p}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clearIn();
    bif.exValid = '0;
    bif.exIsCondBr = '0;
    bif.exPredTaken = '0;
    bif.exExecTaken = '0;
    bif.exTargetMatch = '0;
    bif.exHistory = '0;
    bif.exPrevCnt = '0;
    bif.squashDone = 0;
  endtask

  task automatic setLane(input int i, input bit c, input bit p, input bit e, input bit m, input int h, input int cnt);
    bif.exValid[i] = 1;
    bif.exIsCondBr[i] = c;
    bif.exPredTaken[i] = p;
    bif.exExecTaken[i] = e;
    bif.exTargetMatch[i] = m;
    bif.exHistory[i] = HB'(h);
    bif.exPrevCnt[i] = CB'(cnt);
  endtask

  initial begin
    rst = 0;
    clearIn();
    bif.outReady = 0;
    tick();
    chkEn = 1;
    tick();
    cmp("rst brValid", 64'(bif.brValid), 0);
    cmp("rst inSquash", 64'(bif.inSquash), 0);
    cmp("rst exReady", 64'(bif.exReady), 1);
    cmp("rst mispredCount", 64'(bif.mispredCount), 0);
    rst = 1;
    tick();
    // correct cond branch then mispredicting one in the same cycle
    setLane(0, 1, 1, 1, 1, 5, 1);
    setLane(1, 1, 0, 1, 1, 6, 2);
    bif.outReady = 1;
    tick();
    cmp("mix brValid", 64'(bif.brValid), 64'b11);
    cmp("mix brMispred", 64'(bif.brMispred), 64'b10);
    cmp("mix inSquash", 64'(bif.inSquash), 1);
    cmp("mix mispredCount", 64'(bif.mispredCount), 1);
    cmp("mix hist1", 64'(bif.brHistory[1]), 6);
    // wrong-path results dropped for two squash cycles and the squashDone cycle
    clearIn();
    setLane(0, 1, 0, 0, 1, 50, 0);
    setLane(1, 1, 0, 0, 1, 51, 0);
    tick();
    cmp("sq1 brValid", 64'(bif.brValid), 0);
    cmp("sq1 inSquash", 64'(bif.inSquash), 1);
    tick();
    bif.squashDone = 1;
    tick();
    cmp("sq3 brValid", 64'(bif.brValid), 0);
    cmp("sq3 inSquash", 64'(bif.inSquash), 0);
    clearIn();
    setLane(0, 1, 1, 1, 1, 77, 3);
    tick();
    cmp("resume brValid", 64'(bif.brValid), 64'b01);
    cmp("resume hist0", 64'(bif.brHistory[0]), 77);
    // unconditional target miss in lane 0 shadows lane 1
    clearIn();
    setLane(0, 0, 0, 0, 0, 88, 1);
    setLane(1, 1, 0, 0, 1, 89, 1);
    tick();
    cmp("uncond brValid", 64'(bif.brValid), 64'b01);
    cmp("uncond brMispred", 64'(bif.brMispred), 64'b01);
    cmp("uncond hist0", 64'(bif.brHistory[0]), 88);
    cmp("uncond mispredCount", 64'(bif.mispredCount), 2);
    clearIn();
    bif.squashDone = 1;
    tick();
    cmp("uncond drained", 64'(bif.brValid), 0);
    cmp("uncond run", 64'(bif.inSquash), 0);
    // fill with the output stalled until exReady drops
    clearIn();
    bif.outReady = 0;
    for (int k = 0; k < 4; k++) begin
      setLane(0, 1, 0, 0, 1, 100 + 2 * k, 0);
      setLane(1, 1, 0, 0, 1, 101 + 2 * k, 0);
      tick();
      if (k == 2) cmp("fill6 exReady", 64'(bif.exReady), 1);
    end
    cmp("full exReady", 64'(bif.exReady), 0);
    clearIn();
    setLane(0, 0, 0, 0, 0, 999, 0);
    tick();
    cmp("full ignore inSquash", 64'(bif.inSquash), 0);
    cmp("full ignore mispredCount", 64'(bif.mispredCount), 2);
    cmp("full hold hist0", 64'(bif.brHistory[0]), 100);
    clearIn();
    bif.outReady = 1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      if (j < 4) cmp($sformatf("drain%0d hist0", j), 64'(bif.brHistory[0]), 64'(100 + 2 * j));
      else cmp("drain empty", 64'(bif.brValid), 0);
    end
    // steady push-2/pop-2 across pointer wrap
    for (int c = 0; c < 20; c++) begin
      setLane(0, 1, 1, 1, 1, 200 + 2 * c, 1);
      setLane(1, 0, 0, 0, 1, 201 + 2 * c, 2);
      tick();
      cmp("stream brValid", 64'(bif.brValid), 64'b11);
      cmp("stream hist0", 64'(bif.brHistory[0]), 64'(200 + 2 * c));
      cmp("stream hist1", 64'(bif.brHistory[1]), 64'(201 + 2 * c));
    end
    clearIn();
    tick();
    // reset in the middle of a squash with five entries queued
    bif.outReady = 0;
    for (int k = 0; k < 2; k++) begin
      setLane(0, 1, 0, 0, 1, 300 + k, 0);
      setLane(1, 1, 0, 0, 1, 310 + k, 0);
      tick();
    end
    clearIn();
    setLane(0, 1, 1, 0, 1, 320, 0);
    tick();
    cmp("pre-rst inSquash", 64'(bif.inSquash), 1);
    cmp("pre-rst mispredCount", 64'(bif.mispredCount), 3);
    clearIn();
    rst = 0;
    tick();
    cmp("midrst brValid", 64'(bif.brValid), 0);
    cmp("midrst inSquash", 64'(bif.inSquash), 0);
    cmp("midrst exReady", 64'(bif.exReady), 1);
    cmp("midrst mispredCount", 64'(bif.mispredCount), 0);
    rst = 1;
    // randomized traffic against the reference
    for (int c = 0; c < 4000; c++) begin
      clearIn();
      for (int i = 0; i < IW; i++)
        if ($urandom_range(0, 3) != 0) begin
          bit p;
          p = 1'($urandom);
          setLane(i, 1'($urandom), p, ($urandom_range(0, 9) < 8) ? p : !p, $urandom_range(0, 9) != 0,
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
        end
      bif.outReady = $urandom_range(0, 9) < 6;
      bif.squashDone = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 499) != 0;
      tick();
    end
    chkEn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_result_sender.md
BRANCH_RESULT_SENDER -- requirements
Module: branch_result_sender

Interface
REQ-001 SHALL have parameter ISSUE_WIDTH, default 2: resolved-branch lanes in and out per cycle.
REQ-002 SHALL have parameter HIST_BITS, default 10: global-history width carried per branch.
REQ-003 SHALL have parameter CNT_BITS, default 2: saturating-counter snapshot width.
REQ-004 SHALL have parameter DEPTH, default 8 (power of 2, >= 2*ISSUE_WIDTH): result FIFO entries.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port exValid[ISSUE_WIDTH], input, 1 each: lane carries a resolved branch; lane 0 is oldest.
REQ-008 SHALL have ports exIsCondBr, exPredTaken, exExecTaken, exTargetMatch [ISSUE_WIDTH], input, 1 each: branch class, predicted and actual direction, and predicted-target-correct flag.
REQ-009 SHALL have ports exHistory[ISSUE_WIDTH] (HIST_BITS) and exPrevCnt[ISSUE_WIDTH] (CNT_BITS), input: history and counter value captured at prediction.
REQ-010 SHALL have port exReady, output, 1: block can accept ISSUE_WIDTH results this cycle.
REQ-011 SHALL have port outReady, input, 1: predictor-update side accepts the presented results.
REQ-012 SHALL have ports brValid, brMispred, brExecTaken, brIsCondBr [ISSUE_WIDTH], output, 1 each; brHistory (HIST_BITS) and brPrevCnt (CNT_BITS) [ISSUE_WIDTH], output: results presented to the predictor update port.
REQ-013 SHALL have port squashDone, input, 1: front end has completed redirect after a mispredict.
REQ-014 SHALL have port inSquash, output, 1: block is discarding wrong-path results.
REQ-015 SHALL have port mispredCount, output, 16: saturating count of mispredicts enqueued.

Function
REQ-016 SHALL compute per lane mispred = isCondBr ? (predTaken != execTaken) || (execTaken && !targetMatch) : !targetMatch.
REQ-017 SHALL enqueue a lane only if exValid, exReady, state RUN, and no older lane in the same cycle is a mispredict.
REQ-018 SHALL enqueue accepted lanes in lane order (lane 0 first) in the same edge.
REQ-019 SHALL drop, never enqueue, any lane younger than a mispredicting lane in the same cycle.
REQ-020 SHALL implement states RUN and SQUASH; RUN -> SQUASH on the edge that enqueues a mispredict; SQUASH -> RUN on the edge where squashDone=1.
REQ-021 SHALL drop all exValid lanes while in SQUASH, including the cycle squashDone=1; acceptance resumes the following cycle.
REQ-022 SHALL ignore squashDone while in RUN.
REQ-023 SHALL drive inSquash=1 exactly while in SQUASH.
REQ-024 SHALL drive exReady=1 iff free FIFO entries >= ISSUE_WIDTH, independent of state.
REQ-025 SHALL ignore exValid lanes while exReady=0 (no enqueue, no state or counter change).
REQ-026 SHALL present the oldest min(count, ISSUE_WIDTH) entries on out lanes 0.. combinationally from FIFO head; unused lanes brValid=0, data fields 0.
REQ-027 SHALL pop all presented entries on an edge where outReady=1; hold them unchanged while outReady=0.
REQ-028 SHALL support simultaneous push and pop in one edge; count updates by pushes minus pops.
REQ-029 SHALL wrap head/tail pointers modulo DEPTH; count range 0..DEPTH with no overflow or underflow.
REQ-030 SHALL continue draining older queued entries during SQUASH.
REQ-031 SHALL latency: result accepted at edge N appears on br* lanes in cycle N+1 when FIFO empty before N.
REQ-032 SHALL increment mispredCount by 1 per enqueued mispredict, saturating at 0xFFFF.

Reset
REQ-033 SHALL on rst=0 at an edge: count=0, pointers=0, state RUN, mispredCount=0; no enqueue or pop that edge.
REQ-034 SHALL during and after reset drive brValid=0 all lanes, inSquash=0, exReady=1; reset mid-operation discards all queued entries.

Verification
REQ-035 Lane0 cond, pred=1 exec=1 match=1, lane1 cond pred=0 exec=1; outReady=1 -> next cycle brValid=11, brMispred=01, state SQUASH, mispredCount=1.
REQ-036 Lane0 uncond match=0 plus lane1 valid -> only lane0 queued, brMispred[0]=1; lane1 never appears.
REQ-037 SQUASH, inputs valid 3 cycles, squashDone in cycle 3 -> nothing enqueued; lane valid in cycle 4 appears cycle 5.
REQ-038 outReady=0, push 2 per cycle -> exReady falls after count=8-2+... i.e. at count 7 or 8 (free<2); entries emerge in order once outReady=1.
REQ-039 Push 2/pop 2 every cycle for 20 cycles across pointer wrap -> count constant, order preserved, no loss.
REQ-040 rst=0 with count=5 in SQUASH -> next cycle brValid=0, inSquash=0, exReady=1, mispredCount=0.
